// File: rtl/parking_gate_arbiter_pkg.sv
// parking_pkg: shared definitions for the parking gate arbiter slice.
//   - gate_state_e : arbiter FSM encoding (IDLE / OPEN / GAP)
//   - DIR_ENTRY / DIR_EXIT : encoding of gate_dir / last grant direction
//   - *_DEF : default lot size and timing (40 MHz system clock)
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_GAP  = 2'd2
    } gate_state_e;

    localparam logic DIR_ENTRY = 1'b1;
    localparam logic DIR_EXIT  = 1'b0;

    localparam int CAPACITY_DEF    = 8;
    localparam int OCC_W_DEF       = 4;
    localparam int OPEN_CYCLES_DEF = 120_000_000;  // 3 s
    localparam int GAP_CYCLES_DEF  = 20_000_000;   // 0.5 s
    localparam int TMR_W_DEF       = 27;

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// parking_gate_arbiter_if: request/status bundle between the button
// debouncers (master) and the gate arbiter (slave).
//   entry_pulse, exit_pulse : 1-cycle requests from the debouncers
//   gate_open, gate_dir     : barrier command and direction of last grant
//   occupancy, full, empty  : lot fill state
//   busy                    : arbiter not idle
//   reject_pulse            : 1-cycle notice that a request was dropped
interface parking_gate_arbiter_if
    import parking_pkg::*;
#(
    parameter int OCC_W = OCC_W_DEF
);
    logic             entry_pulse;
    logic             exit_pulse;
    logic             gate_open;
    logic             gate_dir;
    logic [OCC_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             busy;
    logic             reject_pulse;

    modport master (
        output entry_pulse, exit_pulse,
        input  gate_open, gate_dir, occupancy, full, empty, busy, reject_pulse
    );

    modport slave (
        input  entry_pulse, exit_pulse,
        output gate_open, gate_dir, occupancy, full, empty, busy, reject_pulse
    );
endinterface

// File: rtl/parking_gate_arbiter_gate_timer.sv
// gate_timer: loadable down-counter shared by the OPEN and GAP phases.
//   clk, reset : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over count)
//   load_val   : value to load
//   count      : decrement by one; holds at zero
//   zero       : counter currently at zero
module gate_timer
    import parking_pkg::*;
#(
    parameter int TMR_W = TMR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             count,
    output logic             zero
);
    logic [TMR_W-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (count && !zero)
            cnt_d = cnt_q - TMR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares the single barrier between entry and exit
// requesters, tracks occupancy and drops impossible requests.
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : slave side of parking_gate_arbiter_if (requests in, gate and
//            lot status out)
// Requires 2**OCC_W > CAPACITY, OPEN_CYCLES >= 1, TMR_W wide enough for
// max(OPEN_CYCLES, GAP_CYCLES).
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY    = CAPACITY_DEF,
    parameter int OCC_W       = OCC_W_DEF,
    parameter int OPEN_CYCLES = OPEN_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int TMR_W       = TMR_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    parking_gate_arbiter_if.slave  bus
);
    localparam logic [TMR_W-1:0] OPEN_LD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;
    localparam logic [OCC_W-1:0] CAP_V   = OCC_W'(CAPACITY);

    gate_state_e      state_q, state_d;
    logic             pend_in_q, pend_in_d;
    logic             pend_out_q, pend_out_d;
    logic             last_dir_q, last_dir_d;
    logic             granted_q, granted_d;   // any grant since reset
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             reject_q, reject_d;

    logic             clr_in, clr_out;
    logic             win_entry;
    logic             full, empty;
    logic             tmr_load, tmr_zero, tmr_count;
    logic [TMR_W-1:0] tmr_val;

    assign full  = (occ_q == CAP_V);
    assign empty = (occ_q == '0);

    // A pulse landing on the same edge that clears its flag keeps it set.
    assign pend_in_d  = bus.entry_pulse | (pend_in_q  & ~clr_in);
    assign pend_out_d = bus.exit_pulse  | (pend_out_q & ~clr_out);

    assign tmr_count = (state_q != ST_IDLE);

    gate_timer #(.TMR_W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        granted_d  = granted_q;
        occ_d      = occ_q;
        reject_d   = 1'b0;
        clr_in     = 1'b0;
        clr_out    = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = OPEN_LD;
        win_entry  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_in_q || pend_out_q) begin
                    // Contested: exit has priority until an exit has been
                    // granted, then the side that did not go last wins.
                    if (pend_in_q && pend_out_q)
                        win_entry = granted_q && (last_dir_q == DIR_EXIT);
                    else
                        win_entry = pend_in_q;

                    if (win_entry) clr_in  = 1'b1;
                    else           clr_out = 1'b1;

                    if (win_entry ? full : empty) begin
                        reject_d = 1'b1;
                    end else begin
                        last_dir_d = win_entry ? DIR_ENTRY : DIR_EXIT;
                        granted_d  = 1'b1;
                        occ_d      = win_entry ? occ_q + OCC_W'(1) : occ_q - OCC_W'(1);
                        tmr_load   = 1'b1;
                        tmr_val    = OPEN_LD;
                        state_d    = ST_OPEN;
                    end
                end
            end
            ST_OPEN: begin
                if (tmr_zero) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                        state_d  = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pend_in_q  <= 1'b0;
            pend_out_q <= 1'b0;
            last_dir_q <= DIR_EXIT;
            granted_q  <= 1'b0;
            occ_q      <= '0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_in_q  <= pend_in_d;
            pend_out_q <= pend_out_d;
            last_dir_q <= last_dir_d;
            granted_q  <= granted_d;
            occ_q      <= occ_d;
            reject_q   <= reject_d;
        end
    end

    // gate_open follows the state so an async reset drops it at once.
    assign bus.gate_open    = (state_q == ST_OPEN);
    assign bus.gate_dir     = last_dir_q;
    assign bus.occupancy    = occ_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.reject_pulse = reject_q;
endmodule
